// File: rtl/usr_net_pkg.sv
// Shared types for the user UDP transmit path: header layout and framer states.
package usr_net_pkg;

    localparam logic [15:0] UDP_HDR_BYTES = 16'd8;

    typedef struct packed {
        logic [15:0] length;
        logic [15:0] dest_port;
        logic [15:0] src_port;
        logic [31:0] dest_ip;
        logic [31:0] src_ip;
    } usr_hdr_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FILL,
        ST_HDR,
        ST_DRAIN,
        ST_DROP
    } framer_state_t;

endpackage

// File: rtl/usr_tx_framer_if.sv
// Request, payload-in, header-out and payload-out channels of the framer.
interface usr_tx_framer_if #(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned KEEP_WIDTH = 8
);
    logic                  s_req_valid;
    logic                  s_req_ready;
    logic [31:0]           s_req_dest_ip;
    logic [15:0]           s_req_dest_port;

    logic [DATA_WIDTH-1:0] s_axis_tdata;
    logic [KEEP_WIDTH-1:0] s_axis_tkeep;
    logic                  s_axis_tvalid;
    logic                  s_axis_tready;
    logic                  s_axis_tlast;

    logic [111:0]          m_usr_hdr_data;
    logic                  m_usr_hdr_valid;
    logic                  m_usr_hdr_ready;

    logic [DATA_WIDTH-1:0] m_usr_payload_axis_tdata;
    logic [KEEP_WIDTH-1:0] m_usr_payload_axis_tkeep;
    logic                  m_usr_payload_axis_tvalid;
    logic                  m_usr_payload_axis_tready;
    logic                  m_usr_payload_axis_tlast;
    logic                  m_usr_payload_axis_tuser;

    // Framer side
    modport master (
        input  s_req_valid, s_req_dest_ip, s_req_dest_port,
        output s_req_ready,
        input  s_axis_tdata, s_axis_tkeep, s_axis_tvalid, s_axis_tlast,
        output s_axis_tready,
        output m_usr_hdr_data, m_usr_hdr_valid,
        input  m_usr_hdr_ready,
        output m_usr_payload_axis_tdata, m_usr_payload_axis_tkeep,
        output m_usr_payload_axis_tvalid, m_usr_payload_axis_tlast,
        output m_usr_payload_axis_tuser,
        input  m_usr_payload_axis_tready
    );

    // User-logic / downstream side
    modport slave (
        output s_req_valid, s_req_dest_ip, s_req_dest_port,
        input  s_req_ready,
        output s_axis_tdata, s_axis_tkeep, s_axis_tvalid, s_axis_tlast,
        input  s_axis_tready,
        input  m_usr_hdr_data, m_usr_hdr_valid,
        output m_usr_hdr_ready,
        input  m_usr_payload_axis_tdata, m_usr_payload_axis_tkeep,
        input  m_usr_payload_axis_tvalid, m_usr_payload_axis_tlast,
        input  m_usr_payload_axis_tuser,
        output m_usr_payload_axis_tready
    );
endinterface

// File: rtl/usr_sync_fifo.sv
// First-word-fall-through synchronous FIFO with a synchronous flush.
module usr_sync_fifo #(
    parameter int unsigned WIDTH = 73,
    parameter int unsigned DEPTH = 256
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;

    // Extra pointer MSB distinguishes full from empty when the indices match
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign rd_data = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en && !full)
                wr_ptr <= wr_ptr + 1'b1;
            if (rd_en && !empty)
                rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en && !full)
            mem[wr_ptr[AW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/usr_tx_framer.sv
// Store-and-forward framer: buffers one payload, counts its bytes, then emits
// the user UDP header followed by the buffered payload.
module usr_tx_framer
    import usr_net_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned KEEP_WIDTH = 8,
    parameter int unsigned MAX_BEATS  = 184,
    parameter int unsigned FIFO_DEPTH = 256,
    parameter logic [15:0] SRC_PORT   = 16'd1000
) (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic [31:0] local_ip,
    usr_tx_framer_if.master bus,
    output logic [15:0] drop_count,
    output logic        busy
);
    localparam int unsigned FW = DATA_WIDTH + KEEP_WIDTH + 1;
    localparam int unsigned BW = $clog2(MAX_BEATS + 1);

    framer_state_t         state;
    logic [15:0]           byte_count;
    logic [BW-1:0]         beat_count;
    logic [31:0]           dest_ip;
    logic [15:0]           dest_port;
    usr_hdr_t              hdr;
    logic                  req_ready;

    logic                  in_beat;
    logic [15:0]           keep_pop;
    logic [15:0]           bytes_next;
    logic                  overflow;
    logic                  fifo_wr;
    logic                  fifo_rd;
    logic                  fifo_flush;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [FW-1:0]         fifo_head;
    logic [DATA_WIDTH-1:0] head_data;
    logic [KEEP_WIDTH-1:0] head_keep;
    logic                  head_last;
    logic                  pay_valid;
    logic                  drain_last;

    assign bus.s_req_ready   = req_ready;
    assign bus.s_axis_tready = ((state == ST_FILL) && !fifo_full) || (state == ST_DROP);
    assign in_beat           = bus.s_axis_tvalid && bus.s_axis_tready;

    always_comb begin
        keep_pop = '0;
        for (int unsigned i = 0; i < KEEP_WIDTH; i++)
            keep_pop = keep_pop + 16'(bus.s_axis_tkeep[i]);
    end

    assign bytes_next = byte_count + (bus.s_axis_tlast ? keep_pop : 16'(KEEP_WIDTH));
    assign overflow   = (beat_count == BW'(MAX_BEATS));

    // Every flush is a dropped packet, so it also drives drop_count
    assign fifo_wr    = (state == ST_FILL) && in_beat;
    assign fifo_flush = (fifo_wr && bus.s_axis_tlast && (overflow || (bytes_next == 16'd0)))
                     || ((state == ST_DROP) && in_beat && bus.s_axis_tlast);

    usr_sync_fifo #(
        .WIDTH (FW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (aclk),
        .rst_n   (aresetn),
        .flush   (fifo_flush),
        .wr_en   (fifo_wr),
        .wr_data ({bus.s_axis_tdata, bus.s_axis_tkeep, bus.s_axis_tlast}),
        .rd_en   (fifo_rd),
        .rd_data (fifo_head),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign {head_data, head_keep, head_last} = fifo_head;
    assign pay_valid  = (state == ST_DRAIN) && !fifo_empty;
    assign fifo_rd    = pay_valid && bus.m_usr_payload_axis_tready;
    assign drain_last = fifo_rd && head_last;

    assign bus.m_usr_payload_axis_tvalid = pay_valid;
    assign bus.m_usr_payload_axis_tdata  = pay_valid ? head_data : '0;
    assign bus.m_usr_payload_axis_tkeep  = pay_valid ? head_keep : '0;
    assign bus.m_usr_payload_axis_tlast  = pay_valid && head_last;
    assign bus.m_usr_payload_axis_tuser  = 1'b0;
    assign bus.m_usr_hdr_valid           = (state == ST_HDR);
    assign bus.m_usr_hdr_data            = hdr;
    assign busy                          = (state != ST_IDLE);

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state      <= ST_IDLE;
            req_ready  <= 1'b0;
            byte_count <= '0;
            beat_count <= '0;
            dest_ip    <= '0;
            dest_port  <= '0;
            hdr        <= '0;
            drop_count <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    req_ready <= 1'b1;
                    if (bus.s_req_valid && req_ready) begin
                        dest_ip    <= bus.s_req_dest_ip;
                        dest_port  <= bus.s_req_dest_port;
                        byte_count <= '0;
                        beat_count <= '0;
                        req_ready  <= 1'b0;
                        state      <= ST_FILL;
                    end
                end
                ST_FILL: begin
                    if (in_beat) begin
                        byte_count <= bytes_next;
                        beat_count <= beat_count + BW'(1);
                        if (overflow) begin
                            if (bus.s_axis_tlast) begin
                                req_ready <= 1'b1;
                                state     <= ST_IDLE;
                            end else begin
                                state     <= ST_DROP;
                            end
                        end else if (bus.s_axis_tlast) begin
                            if (bytes_next == 16'd0) begin
                                req_ready <= 1'b1;
                                state     <= ST_IDLE;
                            end else begin
                                hdr <= '{length:    bytes_next + UDP_HDR_BYTES,
                                         dest_port: dest_port,
                                         src_port:  SRC_PORT,
                                         dest_ip:   dest_ip,
                                         src_ip:    local_ip};
                                state <= ST_HDR;
                            end
                        end
                    end
                end
                ST_HDR: begin
                    if (bus.m_usr_hdr_ready)
                        state <= ST_DRAIN;
                end
                ST_DRAIN: begin
                    if (drain_last) begin
                        req_ready <= 1'b1;
                        state     <= ST_IDLE;
                    end
                end
                ST_DROP: begin
                    if (in_beat && bus.s_axis_tlast) begin
                        req_ready <= 1'b1;
                        state     <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase

            if (fifo_flush && (drop_count != 16'hFFFF))
                drop_count <= drop_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_usr_tx_framer.sv
// Directed bench for usr_tx_framer with hand-computed headers and payloads.
module tb_usr_tx_framer;
    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;
    logic [31:0] local_ip = '0;
    logic [15:0] drop_count;
    logic        busy;

    int checks = 0;
    int passed = 0;

    logic [63:0] pd [256];
    logic [7:0]  pk [256];

    usr_tx_framer_if #(.DATA_WIDTH(64), .KEEP_WIDTH(8)) bus ();

    usr_tx_framer #(
        .DATA_WIDTH (64),
        .KEEP_WIDTH (8),
        .MAX_BEATS  (184),
        .FIFO_DEPTH (256),
        .SRC_PORT   (16'd1000)
    ) dut (
        .aclk       (aclk),
        .aresetn    (aresetn),
        .local_ip   (local_ip),
        .bus        (bus),
        .drop_count (drop_count),
        .busy       (busy)
    );

    always #5 aclk = ~aclk;

    task automatic chkw(input string tag, input logic [111:0] obs, input logic [111:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic chkb(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    endtask

    task automatic send_req(input logic [31:0] ip, input logic [15:0] port);
        int n = 0;
        @(negedge aclk);
        bus.s_req_valid     = 1'b1;
        bus.s_req_dest_ip   = ip;
        bus.s_req_dest_port = port;
        while (!bus.s_req_ready && n < 500) begin
            @(negedge aclk);
            n++;
        end
        if (!bus.s_req_ready) chkb("req_ready_timeout", bus.s_req_ready, 1'b1);
        else @(posedge aclk);
        @(negedge aclk);
        bus.s_req_valid = 1'b0;
    endtask

    task automatic send_beat(input logic [63:0] d, input logic [7:0] k, input logic l);
        int n = 0;
        @(negedge aclk);
        bus.s_axis_tvalid = 1'b1;
        bus.s_axis_tdata  = d;
        bus.s_axis_tkeep  = k;
        bus.s_axis_tlast  = l;
        while (!bus.s_axis_tready && n < 500) begin
            @(negedge aclk);
            n++;
        end
        if (!bus.s_axis_tready) chkb("axis_tready_timeout", bus.s_axis_tready, 1'b1);
        else @(posedge aclk);
    endtask

    task automatic send_payload(input int n, input logic framed);
        for (int i = 0; i < n; i++)
            send_beat(pd[i], pk[i], (i == n - 1));
        @(negedge aclk);
        bus.s_axis_tvalid = 1'b0;
        bus.s_axis_tlast  = 1'b0;
        chkb("hdr_valid_after_tlast", bus.m_usr_hdr_valid, framed);
        chkb("busy_after_tlast", busy, framed);
    endtask

    task automatic recv_hdr(input logic [111:0] exp);
        int n = 0;
        while (!bus.m_usr_hdr_valid && n < 500) begin
            @(negedge aclk);
            n++;
        end
        chkb("hdr_valid", bus.m_usr_hdr_valid, 1'b1);
        chkw("hdr_data", bus.m_usr_hdr_data, exp);
        bus.m_usr_hdr_ready = 1'b1;
        @(posedge aclk);
        @(negedge aclk);
        bus.m_usr_hdr_ready = 1'b0;
        chkb("hdr_valid_after_hs", bus.m_usr_hdr_valid, 1'b0);
        chkb("pay_valid_after_hdr", bus.m_usr_payload_axis_tvalid, 1'b1);
    endtask

    task automatic recv_payload(input int n, input logic toggle);
        int got = 0;
        int cyc = 0;
        logic ph = 1'b1;
        // Current negedge already follows the header handshake; sample here first
        while (got < n && cyc < 2000) begin
            bus.m_usr_payload_axis_tready = toggle ? ph : 1'b1;
            ph = !ph;
            if (bus.m_usr_payload_axis_tvalid && bus.m_usr_payload_axis_tready) begin
                chkw("pay_data", 112'(bus.m_usr_payload_axis_tdata), 112'(pd[got]));
                chkw("pay_keep", 112'(bus.m_usr_payload_axis_tkeep), 112'(pk[got]));
                chkb("pay_last", bus.m_usr_payload_axis_tlast, (got == n - 1));
                got++;
            end
            @(negedge aclk);
            cyc++;
        end
        bus.m_usr_payload_axis_tready = 1'b0;
        chkw("pay_beats_delivered", 112'(got), 112'(n));
        chkb("pay_valid_after_last", bus.m_usr_payload_axis_tvalid, 1'b0);
        chkb("busy_after_drain", busy, 1'b0);
    endtask

    task automatic check_idle_outputs(input string tag, input logic [15:0] exp_drops);
        chkb({tag, "_hdr_valid"}, bus.m_usr_hdr_valid, 1'b0);
        chkw({tag, "_hdr_data"}, bus.m_usr_hdr_data, 112'h0);
        chkb({tag, "_pay_valid"}, bus.m_usr_payload_axis_tvalid, 1'b0);
        chkw({tag, "_pay_data"}, 112'(bus.m_usr_payload_axis_tdata), 112'h0);
        chkb({tag, "_pay_last"}, bus.m_usr_payload_axis_tlast, 1'b0);
        chkb({tag, "_pay_tuser"}, bus.m_usr_payload_axis_tuser, 1'b0);
        chkb({tag, "_req_ready"}, bus.s_req_ready, 1'b0);
        chkb({tag, "_axis_tready"}, bus.s_axis_tready, 1'b0);
        chkw({tag, "_drop_count"}, 112'(drop_count), 112'(exp_drops));
        chkb({tag, "_busy"}, busy, 1'b0);
    endtask

    initial begin
        bus.s_req_valid = 1'b0;
        bus.s_req_dest_ip = '0;
        bus.s_req_dest_port = '0;
        bus.s_axis_tvalid = 1'b0;
        bus.s_axis_tdata = '0;
        bus.s_axis_tkeep = '0;
        bus.s_axis_tlast = 1'b0;
        bus.m_usr_hdr_ready = 1'b0;
        bus.m_usr_payload_axis_tready = 1'b0;

        // Reset state
        repeat (3) @(posedge aclk);
        @(negedge aclk);
        check_idle_outputs("reset", 16'h0000);
        aresetn = 1'b1;

        // Two full beats -> length 0x18
        local_ip = 32'hC0A80181;
        pd[0] = 64'h0f0f0f0f0f0f0f0f; pk[0] = 8'hFF;
        pd[1] = 64'h0101010101010101; pk[1] = 8'hFF;
        send_req(32'hC0A80180, 16'h04D2);
        send_payload(2, 1'b1);
        recv_hdr(112'h0018_04D2_03E8_C0A80180_C0A80181);
        recv_payload(2, 1'b0);

        // Three beats, last keep 0F -> 8+8+4+8 = 0x1C
        pd[0] = 64'h1111111111111111; pk[0] = 8'hFF;
        pd[1] = 64'h2222222222222222; pk[1] = 8'hFF;
        pd[2] = 64'h3333333344444444; pk[2] = 8'h0F;
        send_req(32'hC0A80180, 16'h04D2);
        send_payload(3, 1'b1);
        recv_hdr(112'h001C_04D2_03E8_C0A80180_C0A80181);
        recv_payload(3, 1'b0);

        // MAX_BEATS+1 beats -> dropped
        for (int i = 0; i < 185; i++) begin
            pd[i] = 64'(i) ^ 64'hA5A5_0000_0000_0000;
            pk[i] = 8'hFF;
        end
        send_req(32'hC0A80180, 16'h04D2);
        send_payload(185, 1'b0);
        chkw("overflow_drop_count", 112'(drop_count), 112'd1);
        chkb("overflow_no_pay", bus.m_usr_payload_axis_tvalid, 1'b0);

        pd[0] = 64'h0f0f0f0f0f0f0f0f; pk[0] = 8'hFF;
        pd[1] = 64'h0101010101010101; pk[1] = 8'hFF;
        send_req(32'hC0A80180, 16'h04D2);
        send_payload(2, 1'b1);
        recv_hdr(112'h0018_04D2_03E8_C0A80180_C0A80181);
        recv_payload(2, 1'b0);

        // Backpressure on header and toggled payload ready; 3*8+8 = 0x20
        local_ip = 32'h0A000001;
        pd[0] = 64'hDEADBEEF00000001; pk[0] = 8'hFF;
        pd[1] = 64'hDEADBEEF00000002; pk[1] = 8'hFF;
        pd[2] = 64'hDEADBEEF00000003; pk[2] = 8'hFF;
        send_req(32'h0A000002, 16'h0050);
        send_payload(3, 1'b1);
        local_ip = 32'hFFFFFFFF;
        for (int i = 0; i < 10; i++) begin
            chkw("bp_hdr_stable", bus.m_usr_hdr_data, 112'h0020_0050_03E8_0A000002_0A000001);
            chkb("bp_pay_valid_low", bus.m_usr_payload_axis_tvalid, 1'b0);
            @(negedge aclk);
        end
        recv_hdr(112'h0020_0050_03E8_0A000002_0A000001);
        recv_payload(3, 1'b1);

        // Reset in the middle of FILL
        local_ip = 32'hC0A80181;
        send_req(32'hC0A80180, 16'h04D2);
        send_beat(64'hAAAAAAAAAAAAAAAA, 8'hFF, 1'b0);
        @(negedge aclk);
        bus.s_axis_tvalid = 1'b0;
        aresetn = 1'b0;
        repeat (2) @(posedge aclk);
        @(negedge aclk);
        check_idle_outputs("midfill_reset", 16'h0000);
        aresetn = 1'b1;

        pd[0] = 64'h0f0f0f0f0f0f0f0f; pk[0] = 8'hFF;
        pd[1] = 64'h0101010101010101; pk[1] = 8'hFF;
        send_req(32'hC0A80180, 16'h04D2);
        send_payload(2, 1'b1);
        recv_hdr(112'h0018_04D2_03E8_C0A80180_C0A80181);
        recv_payload(2, 1'b0);
        chkw("post_reset_drop_count", 112'(drop_count), 112'd0);

        // Zero-byte packet
        pd[0] = 64'h5555555555555555; pk[0] = 8'h00;
        send_req(32'hC0A80180, 16'h04D2);
        send_payload(1, 1'b0);
        chkw("zero_len_drop_count", 112'(drop_count), 112'd1);
        chkb("zero_len_no_pay", bus.m_usr_payload_axis_tvalid, 1'b0);
        repeat (3) @(negedge aclk);
        chkb("zero_len_no_hdr_later", bus.m_usr_hdr_valid, 1'b0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
